// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: issues one data-memory access per instruction,
// aligns load data, and raises alignment, size and bus-timeout exceptions.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] K_ALU = 2'b00, K_LD = 2'b01, K_ST = 2'b10;
  localparam logic [1:0] C_SIZE = 2'b00, C_MIS_LD = 2'b01, C_MIS_ST = 2'b10, C_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          dreq_q, dreq_d, dwe_q, dwe_d;
  logic [31:0]   daddr_q, daddr_d, dwd_q, dwd_d;
  logic [3:0]    dbe_q, dbe_d;
  logic          wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          exc_q, exc_d;
  logic [1:0]    cause_q, cause_d;
  logic [31:0]   eaddr_q, eaddr_d;

  logic          xfer, is_ld, is_st, size_ok, mis, in_exc, tmo;
  logic [1:0]    in_cause;
  logic [3:0]    st_be;
  logic [31:0]   st_wd, ld_sh, ld_val;

  // Decode and exception classification of the incoming request
  always_comb begin
    xfer    = in_valid && ready_q;
    is_ld   = (in_kind == K_LD);
    is_st   = (in_kind == K_ST);
    size_ok = is_ld ? (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                    : (in_funct3 inside {3'b000, 3'b001, 3'b010});
    mis     = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
              ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
    in_exc   = (is_ld || is_st) && (!size_ok || mis);
    in_cause = !size_ok ? C_SIZE : (is_ld ? C_MIS_LD : C_MIS_ST);
    case (in_funct3[1:0])
      2'b00:   begin st_be = 4'b0001 << in_addr[1:0]; st_wd = {4{in_wdata[7:0]}};  end
      2'b01:   begin st_be = 4'b0011 << in_addr[1:0]; st_wd = {2{in_wdata[15:0]}}; end
      default: begin st_be = 4'b1111;                 st_wd = in_wdata;            end
    endcase
  end

  // Load alignment: bring the addressed byte/halfword down to bit 0
  always_comb begin
    ld_sh = dmem_rdata >> {req_q.addr[1:0], 3'b000};
    case (req_q.f3)
      3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_val = {24'h0, ld_sh[7:0]};
      3'b101:  ld_val = {16'h0, ld_sh[15:0]};
      default: ld_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    dreq_d  = 1'b0;
    dwe_d   = 1'b0;
    daddr_d = daddr_q;
    dbe_d   = dbe_q;
    dwd_d   = dwd_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    exc_d   = 1'b0;
    cause_d = cause_q;
    eaddr_d = eaddr_q;
    tmo     = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    case (state_q)
      IDLE: if (xfer) begin
        req_d = '{kind: in_kind, f3: in_funct3, rd: in_rd, addr: in_addr};
        if (in_exc) begin
          exc_d   = 1'b1;
          cause_d = in_cause;
          eaddr_d = in_addr;
        end else if (in_kind == K_ALU) begin
          state_d = WB;
          if (in_rd != 5'd0) begin
            wen_d   = 1'b1;
            waddr_d = in_rd;
            wdata_d = in_addr;
          end
        end else if (is_ld || is_st) begin
          state_d = REQ;
          cnt_d   = '0;
          dreq_d  = 1'b1;
          dwe_d   = is_st;
          daddr_d = {in_addr[31:2], 2'b00};
          dbe_d   = is_st ? st_be : 4'b0000;
          dwd_d   = is_st ? st_wd : dwd_q;
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          state_d = (req_q.kind == K_ST) ? IDLE : RESP;
          cnt_d   = '0;
        end else if (tmo) begin
          state_d = IDLE;
          exc_d   = 1'b1;
          cause_d = C_TMO;
          eaddr_d = req_q.addr;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          dreq_d = 1'b1;
          dwe_d  = (req_q.kind == K_ST);
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_d = WB;
          if (req_q.rd != 5'd0) begin
            wen_d   = 1'b1;
            waddr_d = req_q.rd;
            wdata_d = ld_val;
          end
        end else if (tmo) begin
          state_d = IDLE;
          exc_d   = 1'b1;
          cause_d = C_TMO;
          eaddr_d = req_q.addr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      dreq_q  <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= '0;
      dbe_q   <= '0;
      dwd_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dreq_q  <= dreq_d;
      dwe_q   <= dwe_d;
      daddr_q <= daddr_d;
      dbe_q   <= dbe_d;
      dwd_q   <= dwd_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign in_ready   = ready_q;
  assign dmem_req   = dreq_q;
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_be    = dbe_q;
  assign dmem_wdata = dwd_q;
  assign rf_wr_en   = wen_q;
  assign rf_wr_addr = waddr_q;
  assign rf_wr_data = wdata_q;
  assign exc_valid  = exc_q;
  assign exc_cause  = cause_q;
  assign exc_addr   = eaddr_q;

endmodule
